// File: rtl/parking_state_controller.sv
// parking_state_controller: 4-slot occupancy FSM with exit-priority admission, timed gate and one-shot ack/err pulses
module parking_state_controller #(
  parameter int GATE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  output logic [3:0] state,
  output logic       full,
  output logic [1:0] assigned_slot,
  output logic       gate_open,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, ENTRY_GATE, EXIT_GATE, RELEASE} fsm_t;
  fsm_t       r_fsm, w_fsm_n;
  logic [3:0] r_occ, w_occ_n;
  logic [1:0] r_slot, w_slot_n, w_free;
  logic [7:0] r_cnt, w_cnt_n;
  logic       r_gate, w_gate_n, r_eack, w_eack_n, r_xack, w_xack_n, r_err, w_err_n;
  assign w_free = !r_occ[0] ? 2'd0 : !r_occ[1] ? 2'd1 : !r_occ[2] ? 2'd2 : 2'd3;
  always_comb begin
    w_fsm_n  = r_fsm;
    w_occ_n  = r_occ;
    w_slot_n = r_slot;
    w_cnt_n  = r_cnt;
    w_gate_n = r_gate;
    w_eack_n = 1'b0;
    w_xack_n = 1'b0;
    w_err_n  = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (exit_req) begin
          if (r_occ[exit_slot]) begin
            w_occ_n[exit_slot] = 1'b0;
            w_xack_n = 1'b1;
            w_gate_n = 1'b1;
            w_cnt_n  = 8'd1;
            w_fsm_n  = EXIT_GATE;
          end else begin
            w_err_n = 1'b1;
            w_fsm_n = RELEASE;
          end
        end else if (enter_req) begin
          if (&r_occ) begin
            w_err_n = 1'b1;
            w_fsm_n = RELEASE;
          end else begin
            w_occ_n[w_free] = 1'b1;
            w_slot_n = w_free;
            w_eack_n = 1'b1;
            w_gate_n = 1'b1;
            w_cnt_n  = 8'd1;
            w_fsm_n  = ENTRY_GATE;
          end
        end
      end
      ENTRY_GATE, EXIT_GATE: begin
        if (r_cnt == 8'(GATE_CYCLES)) begin
          w_gate_n = 1'b0;
          w_cnt_n  = 8'd0;
          w_fsm_n  = RELEASE;
        end else begin
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      RELEASE: w_fsm_n = (!enter_req && !exit_req) ? IDLE : RELEASE;
      default: w_fsm_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm  <= IDLE;
      r_occ  <= 4'b0000;
      r_slot <= 2'd0;
      r_cnt  <= 8'd0;
      r_gate <= 1'b0;
      r_eack <= 1'b0;
      r_xack <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_n;
      r_occ  <= w_occ_n;
      r_slot <= w_slot_n;
      r_cnt  <= w_cnt_n;
      r_gate <= w_gate_n;
      r_eack <= w_eack_n;
      r_xack <= w_xack_n;
      r_err  <= w_err_n;
    end
  end
  assign state         = r_occ;
  assign full          = &r_occ;
  assign assigned_slot = r_slot;
  assign gate_open     = r_gate;
  assign entry_ack     = r_eack;
  assign exit_ack      = r_xack;
  assign err           = r_err;
endmodule

// File: tb/tb_parking_state_controller.sv
// tb_parking_state_controller: scoreboard bench, expected events queued by stimulus and popped by a negedge monitor
module tb_parking_state_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter_req = 1'b0, exit_req = 1'b0, en1 = 1'b0;
  logic [1:0] exit_slot = 2'd0;
  logic [3:0] st, st1;
  logic [1:0] aslot, aslot1;
  logic       full, gate, eack, xack, err, full1, gate1, eack1, xack1, err1;
  int         total = 0, passed = 0;
  typedef struct {
    logic [1:0] kind;
    logic [3:0] st;
    logic [1:0] slot;
    logic       gate;
  } ev_t;
  ev_t exp_q[$];
  int  gate_q[$];
  always #5 clk = ~clk;
  parking_state_controller dut (
    .clk(clk), .rst(rst), .enter_req(enter_req), .exit_req(exit_req), .exit_slot(exit_slot),
    .state(st), .full(full), .assigned_slot(aslot), .gate_open(gate),
    .entry_ack(eack), .exit_ack(xack), .err(err)
  );
  parking_state_controller #(.GATE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .enter_req(en1), .exit_req(1'b0), .exit_slot(2'd0),
    .state(st1), .full(full1), .assigned_slot(aslot1), .gate_open(gate1),
    .entry_ack(eack1), .exit_ack(xack1), .err(err1)
  );
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_ev(input logic [1:0] kind, input logic [3:0] s, input logic [1:0] slot, input logic g);
    ev_t e;
    e.kind = kind;
    e.st   = s;
    e.slot = slot;
    e.gate = g;
    exp_q.push_back(e);
  endtask
  int run = 0;
  always @(negedge clk) begin
    if (gate) run++;
    else if (run > 0) begin
      if (gate_q.size() == 0) begin
        total++;
        $display("FAIL gate_len: unexpected gate run of %0d cycles, none expected", run);
      end else chk("gate_len", 8'(run), 8'(gate_q.pop_front()));
      run = 0;
    end
    if (eack | xack | err) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL event: unexpected pulse eack=%b xack=%b err=%b state=%b", eack, xack, err, st);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_kind", {5'd0, err, xack, eack}, e.kind == 2'd0 ? 8'd1 : e.kind == 2'd1 ? 8'd2 : 8'd4);
        chk("ev_state", {4'd0, st}, {4'd0, e.st});
        chk("ev_slot", {6'd0, aslot}, {6'd0, e.slot});
        chk("ev_gate", {7'd0, gate}, {7'd0, e.gate});
        chk("ev_full", {7'd0, full}, {7'd0, &e.st});
      end
    end
  end
  initial begin
    tick(2);
    rst = 1'b0;
    chk("rst_state", {4'd0, st}, 8'h00);
    chk("rst_full", {7'd0, full}, 8'h00);
    chk("rst_slot", {6'd0, aslot}, 8'h00);
    chk("rst_gate", {7'd0, gate}, 8'h00);
    chk("rst_pulses", {5'd0, eack, xack, err}, 8'h00);
    // first entry, request held across the whole gate to exercise RELEASE
    expect_ev(2'd0, 4'b0001, 2'd0, 1'b1); gate_q.push_back(8);
    enter_req = 1'b1; tick(12);
    enter_req = 1'b0; tick(2);
    expect_ev(2'd0, 4'b0011, 2'd1, 1'b1); gate_q.push_back(8);
    enter_req = 1'b1; tick; enter_req = 1'b0; tick(11);
    expect_ev(2'd0, 4'b0111, 2'd2, 1'b1); gate_q.push_back(8);
    enter_req = 1'b1; tick; enter_req = 1'b0; tick(11);
    expect_ev(2'd0, 4'b1111, 2'd3, 1'b1); gate_q.push_back(8);
    enter_req = 1'b1; tick; enter_req = 1'b0; tick(11);
    chk("full_high", {7'd0, full}, 8'h01);
    expect_ev(2'd2, 4'b1111, 2'd3, 1'b0);
    enter_req = 1'b1; tick; enter_req = 1'b0; tick(3);
    expect_ev(2'd1, 4'b1011, 2'd3, 1'b1); gate_q.push_back(8);
    exit_req = 1'b1; exit_slot = 2'd2; tick; exit_req = 1'b0; tick(11);
    expect_ev(2'd0, 4'b1111, 2'd2, 1'b1); gate_q.push_back(8);
    enter_req = 1'b1; tick; enter_req = 1'b0; tick(11);
    expect_ev(2'd1, 4'b1110, 2'd2, 1'b1); gate_q.push_back(8);
    enter_req = 1'b1; exit_req = 1'b1; exit_slot = 2'd0; tick;
    enter_req = 1'b0; exit_req = 1'b0; tick(11);
    expect_ev(2'd0, 4'b1111, 2'd0, 1'b1); gate_q.push_back(8);
    enter_req = 1'b1; tick; enter_req = 1'b0; tick(11);
    rst = 1'b1; tick; rst = 1'b0;
    chk("rst2_state", {4'd0, st}, 8'h00);
    expect_ev(2'd0, 4'b0001, 2'd0, 1'b1); gate_q.push_back(8);
    enter_req = 1'b1; tick; enter_req = 1'b0; tick(11);
    expect_ev(2'd2, 4'b0001, 2'd0, 1'b0);
    exit_req = 1'b1; exit_slot = 2'd3; tick; exit_req = 1'b0; tick(3);
    chk("bad_exit_state", {4'd0, st}, 8'h01);
    // reset in gate cycle 3, with a request pending that must be discarded
    expect_ev(2'd0, 4'b0011, 2'd1, 1'b1); gate_q.push_back(3);
    enter_req = 1'b1; tick; enter_req = 1'b0; tick(2);
    rst = 1'b1; enter_req = 1'b1; tick;
    chk("midgate_gate", {7'd0, gate}, 8'h00);
    chk("midgate_state", {4'd0, st}, 8'h00);
    chk("midgate_full", {7'd0, full}, 8'h00);
    chk("midgate_pulses", {5'd0, eack, xack, err}, 8'h00);
    expect_ev(2'd0, 4'b0001, 2'd0, 1'b1); gate_q.push_back(8);
    rst = 1'b0; tick; enter_req = 1'b0; tick(11);
    en1 = 1'b1; tick;
    chk("g1_gate_on", {7'd0, gate1}, 8'h01);
    chk("g1_ack", {7'd0, eack1}, 8'h01);
    chk("g1_state", {4'd0, st1}, 8'h01);
    en1 = 1'b0; tick;
    chk("g1_gate_off", {7'd0, gate1}, 8'h00);
    tick(2);
    chk("g1_idle_state", {4'd0, st1}, 8'h01);
    chk("events_left", 8'(exp_q.size()), 8'd0);
    chk("gates_left", 8'(gate_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
